pulse_pattern_scheduler: RTL and testbench

PULSE_PATTERN_SCHEDULER -- requirements
Module: pulse_pattern_scheduler

---
 rtl/pulse_pattern_scheduler.sv | 143 ++++++++++++++
 tb/tb_pulse_pattern_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_pattern_scheduler.sv
// Two-requester round-robin job scheduler: serialises a captured pattern MSB first, reps+1 times, then idles GAP cycles.
// Grant edge -> gnt and first pulse bit the next cycle; requests are sampled only while idle (held by requester, never queued).
module pulse_pattern_scheduler #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] value0,
  input  logic [3:0]       reps0,
  input  logic             req1,
  input  logic [WIDTH-1:0] value1,
  input  logic [3:0]       reps1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             owner,
  output logic             busy,
  output logic             pulse,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [3:0]       reps_q, reps_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             win;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins
          win     = (req0 && req1) ? ~last_q : req1;
          pat_d   = win ? value1 : value0;
          reps_d  = win ? reps1 : reps0;
          shift_d = pat_d;
          bit_d   = '0;
          owner_d = win;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          if (reps_q != 4'd0) begin
            shift_d = pat_q;
            reps_d  = reps_q - 4'd1;
            bit_d   = '0;
          end else begin
            shift_d = '0;
            gap_d   = '0;
            done_d  = 1'b1;
            state_d = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end else begin
          shift_d = shift_q << 1;
          bit_d   = bit_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    pulse_d = (state_d == S_SHIFT) && shift_d[WIDTH-1];
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      pat_q   <= '0;
      reps_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign pulse = pulse_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pulse_pattern_scheduler.sv
// Directed bench: instance a uses GAP=2, instance b uses GAP=0; both share the stimulus.
module tb_pulse_pattern_scheduler;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] value0 = 8'h00, value1 = 8'h00;
  logic [3:0] reps0 = 4'd0, reps1 = 4'd0;

  logic a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done;
  logic b_gnt0, b_gnt1, b_owner, b_busy, b_pulse, b_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pulse_pattern_scheduler #(.WIDTH(8), .GAP(2)) dut_a (
    .Clk(Clk), .reset(reset),
    .req0(req0), .value0(value0), .reps0(reps0),
    .req1(req1), .value1(value1), .reps1(reps1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .owner(a_owner),
    .busy(a_busy), .pulse(a_pulse), .done(a_done)
  );

  pulse_pattern_scheduler #(.WIDTH(8), .GAP(0)) dut_b (
    .Clk(Clk), .reset(reset),
    .req0(req0), .value0(value0), .reps0(reps0),
    .req1(req1), .value1(value1), .reps1(reps1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .owner(b_owner),
    .busy(b_busy), .pulse(b_pulse), .done(b_done)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Vectors below are {gnt0, gnt1, owner, busy, pulse, done}
  task automatic test_reset();
    logic [11:0] obs;
    logic [5:0]  oa, ob;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; value0 = 8'h80; value1 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done,
             b_gnt0, b_gnt1, b_owner, b_busy, b_pulse, b_done};
      n_cmp++;
      if (obs !== 12'b0) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, obs, 12'b0);
      end
    end
    reset = 1'b0;
    tick();
    oa = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
    ob = {b_gnt0, b_gnt1, b_owner, b_busy, b_pulse, b_done};
    n_cmp++;
    if (oa !== 6'b100110) begin
      n_err++;
      $display("FAIL first_grant_after_reset_a got=%b exp=%b", oa, 6'b100110);
    end
    n_cmp++;
    if (ob !== 6'b100110) begin
      n_err++;
      $display("FAIL first_grant_after_reset_b got=%b exp=%b", ob, 6'b100110);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_single();
    logic [7:0] pat;
    logic [5:0] exp, obs;
    do_reset();
    pat = 8'hA5; value0 = pat; reps0 = 4'd0; req0 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) req0 = 1'b0;
      exp = {c == 1, 1'b0, 1'b0, c <= 10, (c <= 8) ? pat[8-c] : 1'b0, c == 9};
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_job cyc=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [7:0] pat;
    logic [5:0] exp, obs;
    pat = 8'h81; value1 = pat; reps1 = 4'd2; req1 = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c == 1) req1 = 1'b0;
      exp = {1'b0, c == 1, 1'b1, c <= 26, (c <= 24) ? pat[7-((c-1)%8)] : 1'b0, c == 25};
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL repeat_job cyc=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_tie();
    logic [7:0] pa, pb;
    logic [5:0] exp, obs;
    logic       o;
    int         c;
    do_reset();
    pa = 8'hF0; pb = 8'h0F;
    value0 = pa; value1 = pb; reps0 = 4'd0; reps1 = 4'd0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 33; k++) begin
      tick();
      c = (k % 11) + 1;
      o = ((k / 11) % 2) == 1;
      exp = {c == 1 && !o, c == 1 && o, o, c <= 10,
             (c <= 8) ? (o ? pb[8-c] : pa[8-c]) : 1'b0, c == 9};
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL tie_alternation step=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp, obs;
    do_reset();
    value0 = 8'hFF; value1 = 8'h00; reps0 = 4'd0; req0 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req0 = 1'b0;
      if (c == 4) reset = 1'b1;
      exp = {c == 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL pre_abort cyc=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== 6'b0) begin
        n_err++;
        $display("FAIL after_abort step=%0d got=%b exp=%b", i, obs, 6'b0);
      end
      tick();
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
    n_cmp++;
    if (obs !== 6'b100110) begin
      n_err++;
      $display("FAIL tie_after_abort got=%b exp=%b", obs, 6'b100110);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_zero_gap0();
    logic [5:0] exp, obs;
    do_reset();
    value0 = 8'h00; reps0 = 4'd0; req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        req0 = 1'b0; req1 = 1'b1; value1 = 8'hC3; reps1 = 4'd0;
      end
      if (c == 10) req1 = 1'b0;
      exp = {c == 1, c == 10, c >= 10, c <= 8 || c == 10, c == 10, c == 9};
      obs = {b_gnt0, b_gnt1, b_owner, b_busy, b_pulse, b_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL zero_gap0 cyc=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_capture();
    logic [7:0] pat;
    logic [5:0] exp, obs;
    do_reset();
    pat = 8'hA5; value0 = pat; reps0 = 4'd1; req0 = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) begin
        req0 = 1'b0; value0 = 8'hFF; reps0 = 4'd0;
      end
      exp = {c == 1, 1'b0, 1'b0, c <= 18, (c <= 16) ? pat[7-((c-1)%8)] : 1'b0, c == 17};
      obs = {a_gnt0, a_gnt1, a_owner, a_busy, a_pulse, a_done};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL capture_hold cyc=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_tie();
    test_reset_mid();
    test_zero_gap0();
    test_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
